evrf_wb_arb: RTL and testbench

Write-back arbiter for the shared VRF write bus that feeds every eVRF and MVU-tile VRF (`vrf_wr_en/id/addr/data`). It accepts burst write requests from NREQ producers (MFU0, MFU1, loader) and grants the bus round-robin, one requester at a time, for up to WB_LMT beats per grant. It drives the bus through one register stage and pulses a per-requester done flag when a burst ends.

---
 rtl/npu_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/evrf_wb_arb.sv | 210 +++++++++++++++++++++
 tb/tb_evrf_wb_arb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: write-back arbiter FSM states and requester indices.
package npu_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } wb_arb_state_t;

    localparam int WB_NREQ     = 3;
    localparam int WB_REQ_MFU0 = 0;
    localparam int WB_REQ_MFU1 = 1;
    localparam int WB_REQ_LD   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr (wrapping)
// that is requesting and not masked by i_excl.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic [N-1:0]  i_excl,
    output logic [N-1:0]  o_gnt,
    output logic          o_found
);

    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        o_gnt = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_ptr) + k) % N;
            if (!found && i_req[idx] && !i_excl[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        o_found = found;
    end

endmodule

// File: rtl/evrf_wb_arb.sv
// Round-robin write-back arbiter for the shared VRF write bus: one owner at a
// time, up to WB_LMT beats per grant, bus driven through one register stage.
module evrf_wb_arb
    import npu_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ACCW    = 16,
    parameter int DOTW    = 4,
    parameter int NVRF    = 2,
    parameter int VRFAW   = 6,
    parameter int WB_LMT  = 8,
    parameter int WB_LMTW = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             i_req_valid,
    output logic [NREQ-1:0]             o_req_ready,
    input  logic [NREQ-1:0]             i_req_last,
    input  logic [NREQ*2*NVRF-1:0]      i_req_id,
    input  logic [NREQ*VRFAW-1:0]       i_req_vrf0_addr,
    input  logic [NREQ*VRFAW-1:0]       i_req_vrf1_addr,
    input  logic [NREQ*ACCW*DOTW-1:0]   i_req_data,
    output logic                        o_vrf_wr_en,
    output logic [2*NVRF-1:0]           o_vrf_wr_id,
    output logic [VRFAW-1:0]            o_vrf0_wr_addr,
    output logic [VRFAW-1:0]            o_vrf1_wr_addr,
    output logic [ACCW*DOTW-1:0]        o_vrf_wr_data,
    output logic [NREQ-1:0]             o_wb_done,
    output logic                        o_err
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IDW = 2 * NVRF;
    localparam int DW  = ACCW * DOTW;

    wb_arb_state_t      state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [WB_LMTW-1:0] beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               wr_en_q, wr_en_d;
    logic [IDW-1:0]     wr_id_q, wr_id_d;
    logic [VRFAW-1:0]   wr_a0_q, wr_a0_d;
    logic [VRFAW-1:0]   wr_a1_q, wr_a1_d;
    logic [DW-1:0]      wr_data_q, wr_data_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic               err_q, err_d;

    logic [IDW-1:0]     req_id   [NREQ];
    logic [VRFAW-1:0]   req_a0   [NREQ];
    logic [VRFAW-1:0]   req_a1   [NREQ];
    logic [DW-1:0]      req_data [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_id[gi]   = i_req_id[gi*IDW +: IDW];
            assign req_a0[gi]   = i_req_vrf0_addr[gi*VRFAW +: VRFAW];
            assign req_a1[gi]   = i_req_vrf1_addr[gi*VRFAW +: VRFAW];
            assign req_data[gi] = i_req_data[gi*DW +: DW];
        end
    endgenerate

    // Owner-side view of the request lanes, selected by the one-hot grant.
    logic [PW-1:0]    own_idx;
    logic             sel_last;
    logic [IDW-1:0]   sel_id;
    logic [VRFAW-1:0] sel_a0;
    logic [VRFAW-1:0] sel_a1;
    logic [DW-1:0]    sel_data;

    always_comb begin
        own_idx  = '0;
        sel_last = 1'b0;
        sel_id   = '0;
        sel_a0   = '0;
        sel_a1   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                own_idx  = PW'(i);
                sel_last = i_req_last[i];
                sel_id   = req_id[i];
                sel_a0   = req_a0[i];
                sel_a1   = req_a1[i];
                sel_data = req_data[i];
            end
        end
    end

    logic            acc;
    logic            at_lmt;
    logic            release_now;
    logic [PW-1:0]   next_ptr;
    logic [PW-1:0]   arb_ptr;
    logic [NREQ-1:0] arb_excl;
    logic [NREQ-1:0] arb_gnt;
    logic            arb_found;

    assign acc         = |(gnt_q & i_req_valid);
    assign at_lmt      = (beat_cnt_q == WB_LMTW'(WB_LMT - 1));
    assign release_now = acc && (sel_last || at_lmt);
    assign next_ptr    = (own_idx == PW'(NREQ - 1)) ? '0 : own_idx + PW'(1);

    // One arbiter serves both searches; during handover the releasing owner is masked.
    assign arb_ptr  = (state_q == GRANT) ? next_ptr : rr_ptr_q;
    assign arb_excl = (state_q == GRANT) ? gnt_q : '0;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (arb_ptr),
        .i_excl  (arb_excl),
        .o_gnt   (arb_gnt),
        .o_found (arb_found)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        wr_en_d    = 1'b0;
        wr_id_d    = wr_id_q;
        wr_a0_d    = wr_a0_q;
        wr_a1_d    = wr_a1_q;
        wr_data_d  = wr_data_q;
        done_d     = '0;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d    = GRANT;
                    gnt_d      = arb_gnt;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (acc) begin
                    beat_cnt_d = beat_cnt_q + WB_LMTW'(1);
                    if (sel_id == '0) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_id_d   = sel_id;
                        wr_a0_d   = sel_a0;
                        wr_a1_d   = sel_a1;
                        wr_data_d = sel_data;
                    end
                end
                if (release_now) begin
                    rr_ptr_d   = next_ptr;
                    beat_cnt_d = '0;
                    if (sel_last) begin
                        done_d = gnt_q;
                    end
                    if (arb_found) begin
                        gnt_d = arb_gnt;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_id_q    <= '0;
            wr_a0_q    <= '0;
            wr_a1_q    <= '0;
            wr_data_q  <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_id_q    <= wr_id_d;
            wr_a0_q    <= wr_a0_d;
            wr_a1_q    <= wr_a1_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_req_ready    = gnt_q;
    assign o_vrf_wr_en    = wr_en_q;
    assign o_vrf_wr_id    = wr_id_q;
    assign o_vrf0_wr_addr = wr_a0_q;
    assign o_vrf1_wr_addr = wr_a1_q;
    assign o_vrf_wr_data  = wr_data_q;
    assign o_wb_done      = done_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_evrf_wb_arb.sv
// Randomized bench for evrf_wb_arb against a transaction-level arbitration model.
module tb_evrf_wb_arb;
    import npu_pkg::*;

    localparam int NREQ    = 3;
    localparam int ACCW    = 16;
    localparam int DOTW    = 4;
    localparam int NVRF    = 2;
    localparam int VRFAW   = 6;
    localparam int WB_LMT  = 8;
    localparam int WB_LMTW = 4;
    localparam int IDW     = 2 * NVRF;
    localparam int DW      = ACCW * DOTW;
    localparam int NCYC    = 3000;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ-1:0]        o_req_ready;
    logic [NREQ-1:0]        i_req_last;
    logic [NREQ*IDW-1:0]    i_req_id;
    logic [NREQ*VRFAW-1:0]  i_req_vrf0_addr;
    logic [NREQ*VRFAW-1:0]  i_req_vrf1_addr;
    logic [NREQ*DW-1:0]     i_req_data;
    logic                   o_vrf_wr_en;
    logic [IDW-1:0]         o_vrf_wr_id;
    logic [VRFAW-1:0]       o_vrf0_wr_addr;
    logic [VRFAW-1:0]       o_vrf1_wr_addr;
    logic [DW-1:0]          o_vrf_wr_data;
    logic [NREQ-1:0]        o_wb_done;
    logic                   o_err;

    evrf_wb_arb #(
        .NREQ(NREQ), .ACCW(ACCW), .DOTW(DOTW), .NVRF(NVRF),
        .VRFAW(VRFAW), .WB_LMT(WB_LMT), .WB_LMTW(WB_LMTW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_last      (i_req_last),
        .i_req_id        (i_req_id),
        .i_req_vrf0_addr (i_req_vrf0_addr),
        .i_req_vrf1_addr (i_req_vrf1_addr),
        .i_req_data      (i_req_data),
        .o_vrf_wr_en     (o_vrf_wr_en),
        .o_vrf_wr_id     (o_vrf_wr_id),
        .o_vrf0_wr_addr  (o_vrf0_wr_addr),
        .o_vrf1_wr_addr  (o_vrf1_wr_addr),
        .o_vrf_wr_data   (o_vrf_wr_data),
        .o_wb_done       (o_wb_done),
        .o_err           (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Model: who owns the bus, beats taken in this grant, where the next search starts.
    int             owner;
    int             cnt;
    int             ptr;
    bit             m_err;
    bit             e_wr_en;
    logic [IDW-1:0] e_id;
    logic [VRFAW-1:0] e_a0, e_a1;
    logic [DW-1:0]  e_data;
    logic [NREQ-1:0] e_done;

    // Producer side: beats left in the current burst and its address cursor.
    int         rem  [NREQ];
    logic [VRFAW-1:0] base [NREQ];
    int         bidx [NREQ];

    function automatic int pick(input logic [NREQ-1:0] v, input int start, input int excl);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (start + k) % NREQ;
            if (idx != excl && v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner   = -1;
        cnt     = 0;
        ptr     = 0;
        m_err   = 0;
        e_wr_en = 0;
        e_id    = '0;
        e_a0    = '0;
        e_a1    = '0;
        e_data  = '0;
        e_done  = '0;
        for (int r = 0; r < NREQ; r++) begin
            rem[r]  = 0;
            bidx[r] = 0;
            base[r] = '0;
        end
    endtask

    task automatic model_step(input int cyc);
        int old;
        bit lst;
        logic [IDW-1:0] idv;
        e_wr_en = 0;
        e_done  = '0;
        if (owner >= 0 && i_req_valid[owner]) begin
            idv = i_req_id[owner*IDW +: IDW];
            lst = i_req_last[owner];
            if (idv == '0) m_err = 1;
            else begin
                e_wr_en = 1;
                e_id    = idv;
                e_a0    = i_req_vrf0_addr[owner*VRFAW +: VRFAW];
                e_a1    = i_req_vrf1_addr[owner*VRFAW +: VRFAW];
                e_data  = i_req_data[owner*DW +: DW];
            end
            $display("cyc %0d beat req%0d id=%0h beat#%0d last=%0d", cyc, owner, idv, cnt, lst);
            cnt++;
            rem[owner]--;
            bidx[owner]++;
            if (lst || cnt == WB_LMT) begin
                old = owner;
                ptr = (owner + 1) % NREQ;
                if (lst) e_done[old] = 1'b1;
                owner = pick(i_req_valid, ptr, old);
                cnt = 0;
            end
        end else if (owner < 0) begin
            owner = pick(i_req_valid, ptr, -1);
            cnt = 0;
        end
    endtask

    task automatic drive_inputs(input int cyc);
        logic [IDW-1:0] idv;
        for (int r = 0; r < NREQ; r++) begin
            if (rem[r] == 0 && $urandom_range(0, 3) == 0) begin
                rem[r]  = $urandom_range(1, 12);
                base[r] = VRFAW'($urandom);
                bidx[r] = 0;
            end
            i_req_valid[r] = (rem[r] > 0) && ($urandom_range(0, 4) != 0);
            i_req_last[r]  = (rem[r] == 1);
            idv = (cyc >= 600 && $urandom_range(0, 39) == 0) ? '0 : IDW'($urandom_range(1, 15));
            i_req_id[r*IDW +: IDW]           = idv;
            i_req_vrf0_addr[r*VRFAW +: VRFAW] = base[r] + VRFAW'(bidx[r]);
            i_req_vrf1_addr[r*VRFAW +: VRFAW] = VRFAW'($urandom);
            i_req_data[r*DW +: DW]           = {$urandom, $urandom};
        end
    endtask

    task automatic check_zero(input string ph);
        check({ph, "_ready"}, 64'(o_req_ready), 64'd0);
        check({ph, "_wr_en"}, 64'(o_vrf_wr_en), 64'd0);
        check({ph, "_id"},    64'(o_vrf_wr_id), 64'd0);
        check({ph, "_a0"},    64'(o_vrf0_wr_addr), 64'd0);
        check({ph, "_a1"},    64'(o_vrf1_wr_addr), 64'd0);
        check({ph, "_data"},  64'(o_vrf_wr_data), 64'd0);
        check({ph, "_done"},  64'(o_wb_done), 64'd0);
        check({ph, "_err"},   64'(o_err), 64'd0);
    endtask

    initial begin
        logic [NREQ-1:0] e_ready;
        rst             = 1'b0;
        i_req_valid     = '0;
        i_req_last      = '0;
        i_req_id        = '0;
        i_req_vrf0_addr = '0;
        i_req_vrf1_addr = '0;
        i_req_data      = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            e_ready = (owner >= 0) ? NREQ'(1 << owner) : '0;
            check("ready", 64'(o_req_ready), 64'(e_ready));
            check("wr_en", 64'(o_vrf_wr_en), 64'(e_wr_en));
            check("done",  64'(o_wb_done), 64'(e_done));
            check("err",   64'(o_err), 64'(m_err));
            if (e_wr_en) begin
                check("wr_id",   64'(o_vrf_wr_id), 64'(e_id));
                check("wr_a0",   64'(o_vrf0_wr_addr), 64'(e_a0));
                check("wr_a1",   64'(o_vrf1_wr_addr), 64'(e_a1));
                check("wr_data", 64'(o_vrf_wr_data), 64'(e_data));
            end
            if (cyc == 1200 || cyc == 2100) begin
                // Asynchronous reset mid-traffic: bursts in flight are abandoned.
                #2 rst = 1'b0;
                #1 check_zero("async_rst");
                model_reset();
                i_req_valid = '0;
                i_req_last  = '0;
                @(posedge clk);
                @(negedge clk);
                check_zero("rst_hold");
                rst = 1'b1;
                continue;
            end
            drive_inputs(cyc);
            model_step(cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
